vga_vram_arbiter: RTL and testbench

- Owns the single port of the video RAM and shares it between three users: the VGA display fetch, an external pixel writer and an internal frame-clear engine.
- Sits between the 640x480 VGA timing generator and the frame store.
- Display side: takes the look-ahead pixel coordinates and returns pixel data one cycle later.
- Frame store holds a downscaled image; each stored word covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels. This frees RAM cycles for writes during active video.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_clear_engine.sv | 64 ++++++
 rtl/vga_vram_arbiter.sv | 97 +++++++++
 tb/tb_vga_vram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants, clear-engine state encoding and scaled-address helper
package vga_pkg;

    localparam int VGA_H_PIX = 640;
    localparam int VGA_V_PIX = 480;
    localparam logic [9:0] NO_REQ = 10'h3ff;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Word address of a screen coordinate in a frame store downscaled by 2^shift per axis.
    // The row stride is a constant, so the bit loop reduces to a fixed set of shifted adds.
    function automatic logic [31:0] scaled_addr(input logic [9:0] x, input logic [9:0] y,
                                                input int shift, input int h_pix);
        logic [31:0] row;
        logic [31:0] col;
        logic [31:0] stride;
        logic [31:0] acc;
        row    = 32'(y) >> shift;
        col    = 32'(x) >> shift;
        stride = 32'(h_pix) >> shift;
        acc    = col;
        for (int i = 0; i < 32; i++) begin
            if (stride[i]) begin
                acc = acc + (row << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_clear_engine.sv
// rtl/vga_clear_engine.sv - frame-clear engine: walks every frame word writing a latched colour
module vga_clear_engine
    import vga_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 19200
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    input  logic              slot_free,
    output logic              write_req,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        state;
    clr_state_t        next_state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_col;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A restart request wins over finishing the last word.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (clr_start) next_state = ST_CLEAR;
            ST_CLEAR: if (!clr_start && slot_free && clr_addr == LAST_ADDR) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
            clr_col  <= '0;
        end else if (clr_start) begin
            clr_addr <= '0;
            clr_col  <= clr_color;
        end else if (state == ST_CLEAR && slot_free) begin
            clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
        end
    end

    always_comb begin
        busy       = (state == ST_CLEAR);
        write_req  = (state == ST_CLEAR) && slot_free;
        write_addr = clr_addr;
        write_data = clr_col;
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// rtl/vga_vram_arbiter.sv - shares the single VRAM port between display fetch, frame clear and pixel writer
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int H_PIX       = VGA_H_PIX,
    parameter int V_PIX       = VGA_V_PIX,
    parameter int SCALE_SHIFT = 2,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 15
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [9:0]        pic_x,
    input  logic [9:0]        pic_y,
    output logic [DATA_W-1:0] pic_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                DEPTH    = (H_PIX >> SCALE_SHIFT) * (V_PIX >> SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [9:0]        SUB_MASK = 10'((1 << SCALE_SHIFT) - 1);

    logic              disp_fetch;
    logic [ADDR_W-1:0] disp_addr;
    logic              fetch_d;
    logic [DATA_W-1:0] hold;
    logic              clr_write_req;
    logic [ADDR_W-1:0] clr_write_addr;
    logic [DATA_W-1:0] clr_write_data;

    // Only the first pixel of each horizontal group reads; the rest replay the held word.
    assign disp_fetch = (pic_x != NO_REQ) && ((pic_x & SUB_MASK) == 10'd0);
    assign disp_addr  = ADDR_W'(scaled_addr(pic_x, pic_y, SCALE_SHIFT, H_PIX));

    vga_clear_engine #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .slot_free  (!disp_fetch),
        .write_req  (clr_write_req),
        .write_addr (clr_write_addr),
        .write_data (clr_write_data),
        .busy       (busy)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        if (disp_fetch) begin
            mem_addr = disp_addr;
        end else if (clr_write_req) begin
            mem_we    = 1'b1;
            mem_addr  = clr_write_addr;
            mem_wdata = clr_write_data;
        end else if (!busy && wr_req) begin
            wr_ack = 1'b1;
            // Out-of-frame writes are acknowledged but never reach the RAM.
            if (wr_addr < DEPTH_A) begin
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            fetch_d <= 1'b0;
            hold    <= '0;
        end else begin
            fetch_d <= disp_fetch;
            if (fetch_d) begin
                hold <= mem_rdata;
            end
        end
    end

    assign pic_data = fetch_d ? mem_rdata : hold;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb/tb_vga_vram_arbiter.sv - directed self-checking bench for vga_vram_arbiter
module tb_vga_vram_arbiter;
    import vga_pkg::*;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [9:0]  pic_x, pic_y;
    logic [15:0] pic_data;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        clr_start;
    logic [15:0] clr_color;
    logic        busy;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [9:0]  pic_x0, pic_y0;
    logic [15:0] pic_data0;
    logic        wr_req0;
    logic [18:0] wr_addr0;
    logic [15:0] wr_data0;
    logic        wr_ack0;
    logic        clr_start0;
    logic [15:0] clr_color0;
    logic        busy0;
    logic [18:0] mem_addr0;
    logic        mem_we0;
    logic [15:0] mem_wdata0;
    logic [15:0] mem_rdata0;

    logic [15:0] ram [0:32767];
    int n_cmp = 0;
    int n_err = 0;

    always #5 vga_clk = ~vga_clk;

    vga_vram_arbiter #(.SCALE_SHIFT(2), .DATA_W(16), .ADDR_W(15)) dut (
        .vga_clk(vga_clk), .rst(rst), .pic_x(pic_x), .pic_y(pic_y), .pic_data(pic_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_color(clr_color), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    vga_vram_arbiter #(.SCALE_SHIFT(0), .DATA_W(16), .ADDR_W(19)) dut0 (
        .vga_clk(vga_clk), .rst(rst), .pic_x(pic_x0), .pic_y(pic_y0), .pic_data(pic_data0),
        .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_ack(wr_ack0),
        .clr_start(clr_start0), .clr_color(clr_color0), .busy(busy0),
        .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    always @(posedge vga_clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata  <= ram[mem_addr];
        mem_rdata0 <= mem_addr0[15:0];
    end

    task automatic next_cycle;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        next_cycle();
        @(negedge vga_clk);
        n_cmp++; if (pic_data !== 16'h0) begin n_err++; $display("FAIL reset_pic_data got %h want 0000", pic_data); end
        n_cmp++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 15'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'h0) begin n_err++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_display_read;
        logic [15:0] exp_pd;
        ram[0] = 16'hF800;
        ram[1] = 16'h07E0;
        pic_y = 10'd0;
        for (int x = 0; x <= 8; x++) begin
            pic_x = (x < 8) ? 10'(x) : NO_REQ;
            @(negedge vga_clk);
            if (x == 0 || x == 4) begin
                n_cmp++; if (mem_addr !== 15'(x / 4) || mem_we !== 1'b0)
                    begin n_err++; $display("FAIL disp_fetch_addr x=%0d got addr %h we %b want addr %h we 0", x, mem_addr, mem_we, x / 4); end
            end else begin
                n_cmp++; if (mem_addr !== 15'h0 || mem_we !== 1'b0)
                    begin n_err++; $display("FAIL disp_no_read x=%0d got addr %h we %b want 0 0", x, mem_addr, mem_we); end
            end
            if (x >= 1) begin
                exp_pd = (x <= 4) ? 16'hF800 : 16'h07E0;
                n_cmp++; if (pic_data !== exp_pd)
                    begin n_err++; $display("FAIL disp_pic_data x=%0d got %h want %h", x - 1, pic_data, exp_pd); end
            end
            next_cycle();
        end
    endtask

    task automatic test_writer_active;
        pic_y = 10'd0;
        wr_req = 1'b1; wr_addr = 15'd5; wr_data = 16'h001F;
        for (int x = 0; x < 4; x++) begin
            pic_x = 10'(x);
            if (x == 2) wr_req = 1'b0;
            @(negedge vga_clk);
            if (x == 1) begin
                n_cmp++; if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd5 || mem_wdata !== 16'h001F)
                    begin n_err++; $display("FAIL wr_active_grant got ack %b we %b addr %h data %h want 1 1 0005 001f", wr_ack, mem_we, mem_addr, mem_wdata); end
            end else begin
                n_cmp++; if (wr_ack !== 1'b0)
                    begin n_err++; $display("FAIL wr_active_noack x=%0d got %b want 0", x, wr_ack); end
            end
            next_cycle();
        end
        pic_x = NO_REQ; pic_y = NO_REQ;
        n_cmp++; if (ram[5] !== 16'h001F) begin n_err++; $display("FAIL wr_active_ram got %h want 001f", ram[5]); end
    endtask

    task automatic test_oob_write;
        pic_x = NO_REQ; pic_y = NO_REQ;
        wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 16'hABCD;
        @(negedge vga_clk);
        n_cmp++; if (wr_ack !== 1'b1 || mem_we !== 1'b0)
            begin n_err++; $display("FAIL wr_oob got ack %b we %b want 1 0", wr_ack, mem_we); end
        next_cycle();
        wr_addr = 15'd19199; wr_data = 16'h1357;
        @(negedge vga_clk);
        n_cmp++; if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd19199)
            begin n_err++; $display("FAIL wr_last_word got ack %b we %b addr %0d want 1 1 19199", wr_ack, mem_we, mem_addr); end
        next_cycle();
        wr_req = 1'b0;
    endtask

    task automatic test_clear;
        int busy_cnt, seq_err;
        logic [14:0] exp_a;
        logic done;
        pic_x = NO_REQ; pic_y = NO_REQ;
        wr_req = 1'b0; clr_start = 1'b1; clr_color = 16'hFFFF;
        @(negedge vga_clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_start_busy got %b want 0", busy); end
        next_cycle();
        clr_start = 1'b0; clr_color = 16'h0000;
        wr_req = 1'b1; wr_addr = 15'd7; wr_data = 16'h1234;
        busy_cnt = 0; seq_err = 0; exp_a = '0; done = 1'b0;
        for (int c = 0; c < 19300 && !done; c++) begin
            @(negedge vga_clk);
            if (busy) begin
                if (mem_we !== 1'b1 || mem_addr !== exp_a || mem_wdata !== 16'hFFFF || wr_ack !== 1'b0) seq_err++;
                exp_a++;
                busy_cnt++;
                next_cycle();
            end else begin
                done = 1'b1;
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL clr_timeout got done %b want 1", done); end
        n_cmp++; if (busy_cnt !== 19200) begin n_err++; $display("FAIL clr_busy_cycles got %0d want 19200", busy_cnt); end
        n_cmp++; if (seq_err !== 0) begin n_err++; $display("FAIL clr_sequence got %0d bad cycles want 0", seq_err); end
        n_cmp++; if (wr_ack !== 1'b1 || mem_addr !== 15'd7 || mem_wdata !== 16'h1234)
            begin n_err++; $display("FAIL clr_then_write got ack %b addr %h data %h want 1 0007 1234", wr_ack, mem_addr, mem_wdata); end
        next_cycle();
        wr_req = 1'b0;
        n_cmp++; if (ram[0] !== 16'hFFFF || ram[19199] !== 16'hFFFF || ram[7] !== 16'h1234)
            begin n_err++; $display("FAIL clr_ram got %h %h %h want ffff ffff 1234", ram[0], ram[19199], ram[7]); end
    endtask

    task automatic test_restart_reset;
        pic_x = NO_REQ; pic_y = NO_REQ; wr_req = 1'b0;
        clr_start = 1'b1; clr_color = 16'hAAAA;
        next_cycle();
        clr_start = 1'b0;
        for (int i = 0; i < 100; i++) next_cycle();
        clr_start = 1'b1; clr_color = 16'h5555;
        @(negedge vga_clk);
        n_cmp++; if (mem_addr !== 15'd100 || mem_wdata !== 16'hAAAA)
            begin n_err++; $display("FAIL restart_before got addr %0d data %h want 100 aaaa", mem_addr, mem_wdata); end
        next_cycle();
        clr_start = 1'b0;
        @(negedge vga_clk);
        n_cmp++; if (busy !== 1'b1 || mem_addr !== 15'd0 || mem_wdata !== 16'h5555)
            begin n_err++; $display("FAIL restart_after got busy %b addr %0d data %h want 1 0 5555", busy, mem_addr, mem_wdata); end
        next_cycle();
        next_cycle();
        pic_x = 10'd0; pic_y = 10'd0;
        @(negedge vga_clk);
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL clr_stall_fetch got we %b want 0", mem_we); end
        next_cycle();
        pic_x = NO_REQ; pic_y = NO_REQ;
        @(negedge vga_clk);
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 15'd2)
            begin n_err++; $display("FAIL clr_stall_resume got we %b addr %0d want 1 2", mem_we, mem_addr); end
        next_cycle();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || mem_we !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_clear got busy %b we %b want 0 0", busy, mem_we); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_s0_lines;
        int rd_ok, ack_act, ack_blank, first_ack;
        rd_ok = 0; ack_act = 0; ack_blank = 0; first_ack = -1;
        wr_req0 = 1'b1; wr_addr0 = 19'd3; wr_data0 = 16'h0F0F;
        for (int y = 0; y < 2; y++) begin
            for (int h = 0; h < 800; h++) begin
                pic_x0 = (h < 640) ? 10'(h) : NO_REQ;
                pic_y0 = 10'(y);
                @(negedge vga_clk);
                if (first_ack < 0 && wr_ack0 === 1'b1) first_ack = h;
                if (h < 640) begin
                    if (mem_we0 === 1'b0 && mem_addr0 === 19'(y * 640 + h)) rd_ok++;
                    if (wr_ack0 !== 1'b0) ack_act++;
                end else if (wr_ack0 === 1'b1 && mem_we0 === 1'b1 && mem_addr0 === 19'd3) begin
                    ack_blank++;
                end
                next_cycle();
            end
        end
        wr_req0 = 1'b0; pic_x0 = NO_REQ; pic_y0 = NO_REQ;
        n_cmp++; if (rd_ok !== 1280) begin n_err++; $display("FAIL s0_reads got %0d want 1280", rd_ok); end
        n_cmp++; if (ack_act !== 0) begin n_err++; $display("FAIL s0_active_acks got %0d want 0", ack_act); end
        n_cmp++; if (ack_blank !== 320) begin n_err++; $display("FAIL s0_blank_acks got %0d want 320", ack_blank); end
        n_cmp++; if (first_ack !== 640) begin n_err++; $display("FAIL s0_first_ack got %0d want 640", first_ack); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 16'h0;
        rst = 1'b1;
        pic_x = NO_REQ; pic_y = NO_REQ; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clr_start = 1'b0; clr_color = '0;
        pic_x0 = NO_REQ; pic_y0 = NO_REQ; wr_req0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        clr_start0 = 1'b0; clr_color0 = '0;
        test_reset();
        test_display_read();
        test_writer_active();
        test_oob_write();
        test_clear();
        test_restart_reset();
        test_s0_lines();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
